// File: rtl/calc_display.sv
// calc_display: converts the ALU result to BCD and drives a 4-digit, multiplexed 7-segment display
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   value[7:0]      ALU result magnitude (not clock-aligned, registered on entry)
//   control[2:0]    ALU status: 0 normal, 1 negative, 2 divide-by-zero, 4 scaled by 100
//   seg[6:0]        segments {g,f,e,d,c,b,a}, active-low
//   dp              decimal point, active-low
//   an[3:0]         digit anodes, active-low one-hot, an[3] leftmost
//   busy            high while a conversion is in progress
//   bcd[11:0]       committed BCD {hundreds,tens,ones}
module calc_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  value,
    input  logic [2:0]  control,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        busy,
    output logic [11:0] bcd
);
    localparam int CW = $clog2(REFRESH_DIV);
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
    state_t      state_q, state_d;
    logic [7:0]  cap_val_q, ld_val_q, last_val_q;
    logic [2:0]  cap_ctl_q, ctl_q, last_ctl_q, mode_q;
    logic [19:0] sr_q, adj;
    logic [2:0]  cnt_q;
    logic [11:0] bcd_q;
    logic        pending_q, primed_q, start;
    logic [CW-1:0] refresh_q;
    logic [1:0]  idx_q, nidx;
    logic [6:0]  seg_q, seg_d, dig0, dig1, dig2, dig3;
    logic        dp_q, dp_d, tc;
    logic [3:0]  an_q;
    logic [2:0]  m;
    logic [3:0]  h, t, o;
    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0: dec = 7'h40;
            4'd1: dec = 7'h79;
            4'd2: dec = 7'h24;
            4'd3: dec = 7'h30;
            4'd4: dec = 7'h19;
            4'd5: dec = 7'h12;
            4'd6: dec = 7'h02;
            4'd7: dec = 7'h78;
            4'd8: dec = 7'h00;
            4'd9: dec = 7'h10;
            default: dec = 7'h7F;
        endcase
    endfunction
    // primed_q holds off the post-reset conversion until the capture registers
    // hold the live input, so the forced conversion converts the current value.
    assign start = primed_q && (pending_q || {cap_val_q, cap_ctl_q} != {last_val_q, last_ctl_q});
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q == IDLE   ? (start ? SHIFT : IDLE) :
                  state_q == SHIFT  ? (cnt_q == 3'd7 ? COMMIT : SHIFT) : IDLE;
    end
    always_comb begin
        busy = state_q != IDLE;
    end
    always_comb begin
        adj = sr_q;
        for (int k = 0; k < 3; k++)
            if (adj[8+4*k +: 4] >= 4'd5) adj[8+4*k +: 4] = adj[8+4*k +: 4] + 4'd3;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_val_q  <= '0;
            cap_ctl_q  <= '0;
            ld_val_q   <= '0;
            ctl_q      <= '0;
            last_val_q <= '0;
            last_ctl_q <= '0;
            mode_q     <= '0;
            sr_q       <= '0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            pending_q  <= 1'b1;
            primed_q   <= 1'b0;
        end else begin
            cap_val_q <= value;
            cap_ctl_q <= control;
            primed_q  <= 1'b1;
            case (state_q)
                IDLE: if (start) begin
                    sr_q      <= {12'b0, cap_val_q};
                    ld_val_q  <= cap_val_q;
                    ctl_q     <= cap_ctl_q;
                    pending_q <= 1'b0;
                    cnt_q     <= '0;
                end
                SHIFT: begin
                    sr_q  <= adj << 1;
                    cnt_q <= cnt_q + 3'd1;
                end
                COMMIT: begin
                    bcd_q      <= sr_q[19:8];
                    mode_q     <= ctl_q;
                    last_val_q <= ld_val_q;
                    last_ctl_q <= ctl_q;
                end
                default: ;
            endcase
        end
    end
    assign bcd = bcd_q;
    always_comb begin
        m    = (mode_q == 3'd1 || mode_q == 3'd2 || mode_q == 3'd4) ? mode_q : 3'd0;
        h    = bcd_q[11:8];
        t    = bcd_q[7:4];
        o    = bcd_q[3:0];
        nidx = idx_q + 2'd1;
        dig3 = m == 3'd1 ? 7'h3F : 7'h7F;
        dig2 = m == 3'd2 ? 7'h06 : (m != 3'd4 && h == 4'd0) ? 7'h7F : dec(h);
        dig1 = m == 3'd2 ? 7'h2F : (m != 3'd4 && h == 4'd0 && t == 4'd0) ? 7'h7F : dec(t);
        dig0 = m == 3'd2 ? 7'h2F : dec(o);
        seg_d = nidx == 2'd0 ? dig0 : nidx == 2'd1 ? dig1 : nidx == 2'd2 ? dig2 : dig3;
        dp_d  = !(m == 3'd4 && nidx == 2'd2);
        tc    = refresh_q == CW'(REFRESH_DIV - 1);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_q <= '0;
            idx_q     <= '0;
            seg_q     <= 7'h7F;
            dp_q      <= 1'b1;
            an_q      <= 4'hF;
        end else begin
            refresh_q <= tc ? '0 : refresh_q + CW'(1);
            if (tc) begin
                idx_q <= nidx;
                seg_q <= seg_d;
                dp_q  <= dp_d;
                an_q  <= ~(4'b0001 << nidx);
            end
        end
    end
    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;
endmodule

// File: doc/calc_display.md
Name: calc_display

Overview:
- Output stage directly downstream of the calculator ALU. Consumes the ALU's 8-bit result and 3-bit control code.
- Converts the result to BCD with a sequential shift-add-3 (double-dabble) engine, one bit per clock.
- Formats a sign, error or fixed-point display mode.
- Drives a 4-digit, common-anode, time-multiplexed 7-segment display.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit stays lit before the scan advances (legal range 2 or more).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- value  in  8  ALU result (unsigned magnitude)
- control  in  3  ALU status: 0 normal, 1 negative, 2 divide-by-zero, 4 quotient scaled by 100; other codes treated as 0
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- an  out  4  digit anodes, active-low one-hot; an[3] is the leftmost digit
- busy  out  1  high while a conversion is in progress
- bcd  out  12  committed BCD {hundreds,tens,ones}, for verification

Behaviour:
- Reset (asynchronous): all registers clear.
  - seg=7'h7F, dp=1, an=4'hF, busy=0, bcd=0, scan index=0, refresh counter=0.
  - A "pending" flag is set, which forces one conversion right after reset.
- Input capture:
  - value and control are registered every clock into cap_val and cap_ctl. The ALU output is not clock-aligned.
- Conversion FSM, states IDLE, SHIFT, COMMIT:
  - IDLE: if pending=1, or {cap_val,cap_ctl} differs from the last committed pair, load a 20-bit shift register {12'b0,cap_val}, latch cap_ctl, clear pending, set busy=1, go to SHIFT.
  - SHIFT: 8 cycles, counted 0..7. Each cycle, add 3 to every BCD nibble that is 5 or more, then shift left by 1. After the 8th shift, go to COMMIT.
  - COMMIT: 1 cycle. Copy the BCD and latched control into the display registers atomically, store the committed pair, set busy=0, go to IDLE.
  - Latency: busy is high for exactly 9 cycles. An input change reaches the display registers no more than 11 cycles after the input edge.
  - Input changes during SHIFT or COMMIT are ignored. They are detected in the first IDLE cycle after COMMIT; no input is lost, only intermediate values are skipped.
  - Reset mid-conversion: the conversion is aborted, the display goes dark, and a fresh conversion starts after reset is released.
- Display format (digits 3..0), derived from the committed registers:
  - mode 0: digit3 blank; digits 2..0 show H,T,O. H is blanked if 0; T is blanked if H=0 and T=0. O is always shown.
  - mode 1: identical to mode 0, but digit3 shows '-'.
  - mode 2: blank,'E','r','r'. The BCD is ignored.
  - mode 4: digit3 blank; H,T,O with no blanking. dp is lit on digit2, giving H.TO.
  - dp is off on every other digit and in every other mode.
- Segment codes (gfedcba, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - '-'=3F, 'E'=06, 'r'=2F, blank=7F
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On the terminal count the scan index advances 0→1→2→3→0, and seg, dp and an are registered for the new index. Index i asserts an[i] low.
  - Until the first terminal count after reset, an stays 4'hF.
  - The scan runs independently of conversion. Display registers change only at COMMIT, so no digit ever shows a half-converted value.

Test Plan:
- Run all scenarios with REFRESH_DIV=4.
- Reset release, then value=123, control=0 -> busy high for 9 cycles; bcd=12'h123; scan shows an=E,D,B,7 with seg=30,24,79,7F; dp=1 throughout.
- value=5, control=1 -> digits blank,blank,'5' plus '-' on digit3: digit0 12, digit1 7F, digit2 7F, digit3 3F.
- value=200, control=2 -> digit3..0 = 7F,06,2F,2F; bcd=12'h200 is still committed.
- value=50, control=4 -> digit2=40 with dp=0, digit1=12, digit0=40, digit3=7F. value=255, control=0 -> bcd=12'h255.
- Change value from 10 to 99 on the 3rd SHIFT cycle -> first commit is 12'h010; a second conversion starts immediately after and commits 12'h099; busy drops exactly twice.
- Assert rst during SHIFT -> seg=7F, an=F, busy=0 immediately, asynchronously. After release, one conversion of the current input starts without any input change.
